button_events: RTL and testbench
================================

# button_events

Classifies a debounced pushbutton level into discrete user events: press, release, short press, double click, long press and auto-repeat. It sits directly downstream of the debouncer and consumes its clean level output. It turns that level into single-cycle event strobes for menu, UI and control logic. All event outputs are registered one-cycle pulses in the `clk` domain.

## Interface
- `LONG_CNT`, default 50_000_000: number of cycles the button must be held after `press` before `long_press` fires (1 s at 50 MHz).
- `DBL_CNT`, default 12_500_000: maximum gap, in cycles after `release`, within which a second press counts as a double click (250 ms).
- `RPT_CNT`, default 5_000_000: auto-repeat period in cycles while in long hold. Value 0 disables repeat.
- `CW`, default 32: counter width. Requires `LONG_CNT`, `DBL_CNT`, `RPT_CNT` < 2^CW, and `LONG_CNT`, `DBL_CNT` ≥ 2.
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `btn` in 1: debounced button level, synchronous to `clk`. No synchronizer is inside the block.
- `press` out 1: pulse on each detected rising edge of `btn`.
- `release` out 1: pulse on each detected falling edge of `btn`.
- `short_press` out 1: pulse when a single press/release completes without a long hold or a second press.
- `double_click` out 1: pulse coincident with the second `press` of a double click.
- `long_press` out 1: pulse once per hold when the hold reaches `LONG_CNT`.
- `repeat_tick` out 1: pulse every `RPT_CNT` cycles after `long_press` while still held.
- `held` out 1: registered copy of `btn`.

## Operation
- **Edge detection.** `btn_q` holds `btn` from the previous cycle.
  - rise = `btn & ~btn_q`
  - fall = `~btn & btn_q`
  - `held` = `btn_q`.
- **State machine.** States are IDLE, DOWN1, GAP, DOWN2, LONG. A single counter `cnt[CW-1:0]` is cleared on every state entry.
- **IDLE:**
  - rise → `press`, go to DOWN1.
- **DOWN1.** Priority order:
  - fall → `release`, go to GAP.
  - `cnt == LONG_CNT-1` → `long_press`, go to LONG.
  - otherwise `cnt++`.
- **GAP.** Priority order:
  - rise → `press` and `double_click`, go to DOWN2.
  - `cnt == DBL_CNT-1` → `short_press`, go to IDLE.
  - otherwise `cnt++`.
- **DOWN2:**
  - fall → `release`, go to IDLE.
  - No long, repeat or short detection in this state; the double click consumes the sequence.
- **LONG.** Priority order:
  - fall → `release`, go to IDLE. No `short_press` is generated.
  - `RPT_CNT != 0` and `cnt == RPT_CNT-1` → `repeat_tick`, `cnt <= 0`.
  - otherwise `cnt++`.
  - When `RPT_CNT == 0`, `cnt` holds at 0.
- **Pulse exclusivity.** At most one of `short_press`, `long_press`, `double_click`, `repeat_tick` fires per cycle. `press` coincides only with `double_click`.
- **Reset.** State = IDLE, `cnt` = 0, `btn_q` = 0. Every output resets to 0.
  - `btn` high on the first cycle after reset is a rise and produces `press`.
  - Reset mid-sequence abandons it with no pulses.

## Timing
- All outputs are registered. Each pulse is exactly 1 cycle wide.
- `press` / `release` go high in the cycle after the clock edge that first samples the new `btn` level.
- `long_press` fires exactly `LONG_CNT` cycles after `press`.
- `short_press` fires exactly `DBL_CNT` cycles after `release`, provided no rise occurred.
- First `repeat_tick` fires `RPT_CNT` cycles after `long_press`, then every `RPT_CNT` cycles.
- Simultaneous events:
  - A fall sampled on the `long_press` edge wins: `release` fires, no `long_press`.
  - A rise sampled on the `short_press` timeout edge wins: `double_click` fires, no `short_press`.
- Maximum event rate is one state transition per cycle. Back-to-back sequences need no idle cycle.

## Test plan
Bench parameters: `LONG_CNT=20`, `DBL_CNT=10`, `RPT_CNT=5`.
- **Reset with button held:** `rst` high 3 cycles with `btn=1` → all outputs 0. On release of `rst`, `press` fires 1 cycle later and `held=1`.
- **Short press:** `btn` high 5 cycles, then low → `press`, then `release`, then `short_press` exactly 10 cycles after `release`. No other pulses.
- **Double click:** high 5, low 4, high 5, low → `double_click` coincides with the second `press`, then `release`. No `short_press`, no `long_press`.
- **Long press with repeat:** high 37 cycles → `long_press` 20 cycles after `press`, `repeat_tick` at +25, +30, +35. On fall, `release` only; no `short_press`.
- **Boundary, long:** fall sampled on the 20th edge after `press` → `release`, no `long_press`, then `short_press` 10 cycles later.
- **Boundary, double:** rise sampled on the 10th edge after the fall → `double_click`. Rise on the 11th edge → `short_press`, then a fresh `press` with no `double_click`.

Source files
------------

// File: rtl/button_events.sv
// button_events: classify a debounced button level into press/release/short/double/long/repeat strobes
module button_events #(
    parameter int LONG_CNT = 50_000_000,
    parameter int DBL_CNT  = 12_500_000,
    parameter int RPT_CNT  = 5_000_000,
    parameter int CW       = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press,
    output logic released,
    output logic short_press,
    output logic double_click,
    output logic long_press,
    output logic repeat_tick,
    output logic held
);
    typedef enum logic [2:0] {IDLE, DOWN1, GAP, DOWN2, LONG} state_t;

    localparam logic [CW-1:0] LONG_M1 = CW'(LONG_CNT - 1);
    localparam logic [CW-1:0] DBL_M1  = CW'(DBL_CNT - 1);
    localparam logic [CW-1:0] RPT_M1  = CW'(RPT_CNT - 1);
    localparam logic          RPT_ON  = RPT_CNT != 0;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          btn_q;
    logic          rise;
    logic          fall;

    assign rise = btn & ~btn_q;
    assign fall = ~btn & btn_q;
    assign held = btn_q;

    // Event FSM: one shared counter cleared on every state entry, all strobes registered
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            btn_q        <= 1'b0;
            press        <= 1'b0;
            released     <= 1'b0;
            short_press  <= 1'b0;
            double_click <= 1'b0;
            long_press   <= 1'b0;
            repeat_tick  <= 1'b0;
        end else begin
            btn_q        <= btn;
            press        <= 1'b0;
            released     <= 1'b0;
            short_press  <= 1'b0;
            double_click <= 1'b0;
            long_press   <= 1'b0;
            repeat_tick  <= 1'b0;
            case (state)
                IDLE: if (rise) begin
                    press <= 1'b1;
                    state <= DOWN1;
                    cnt   <= '0;
                end
                DOWN1: if (fall) begin
                    released <= 1'b1;
                    state    <= GAP;
                    cnt      <= '0;
                end else if (cnt == LONG_M1) begin
                    long_press <= 1'b1;
                    state      <= LONG;
                    cnt        <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                GAP: if (rise) begin
                    press        <= 1'b1;
                    double_click <= 1'b1;
                    state        <= DOWN2;
                    cnt          <= '0;
                end else if (cnt == DBL_M1) begin
                    short_press <= 1'b1;
                    state       <= IDLE;
                    cnt         <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                DOWN2: if (fall) begin
                    released <= 1'b1;
                    state    <= IDLE;
                    cnt      <= '0;
                end
                LONG: if (fall) begin
                    released <= 1'b1;
                    state    <= IDLE;
                    cnt      <= '0;
                end else if (RPT_ON && cnt == RPT_M1) begin
                    repeat_tick <= 1'b1;
                    cnt         <= '0;
                end else if (RPT_ON) begin
                    cnt <= cnt + 1'b1;
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_button_events.sv
// tb_button_events: directed cycle-by-cycle checks of button_events strobes
module tb_button_events;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn = 1'b1;
    logic press, released, short_press, double_click, long_press, repeat_tick, held;
    logic [5:0] ev;
    int n_chk = 0;
    int n_fail = 0;

    localparam logic [5:0] Z = 6'b000000;
    localparam logic [5:0] P = 6'b100000;
    localparam logic [5:0] R = 6'b010000;
    localparam logic [5:0] S = 6'b001000;
    localparam logic [5:0] D = 6'b000100;
    localparam logic [5:0] L = 6'b000010;
    localparam logic [5:0] T = 6'b000001;

    button_events #(.LONG_CNT(20), .DBL_CNT(10), .RPT_CNT(5), .CW(8)) dut (
        .clk(clk), .rst(rst), .btn(btn),
        .press(press), .released(released), .short_press(short_press),
        .double_click(double_click), .long_press(long_press),
        .repeat_tick(repeat_tick), .held(held)
    );

    assign ev = {press, released, short_press, double_click, long_press, repeat_tick};

    always #5 clk = ~clk;

    // drive btn/rst for one edge, then compare {held, events} just after it
    task automatic tick(input logic r, input logic b, input logic [5:0] exp, input string tag);
        logic [6:0] want;
        rst = r;
        btn = b;
        @(posedge clk);
        #1;
        want = {b & ~r, exp};
        n_chk++;
        assert ({held, ev} === want)
        else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, {held, ev}, want);
        end
    endtask

    task automatic quiet(input logic b, input int cycles, input string tag);
        for (int i = 0; i < cycles; i++) tick(1'b0, b, Z, tag);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, Z, "reset_hold");
        tick(1'b0, 1'b1, P, "press_after_reset");
        tick(1'b0, 1'b0, R, "release_after_reset");
        quiet(1'b0, 9, "gap_after_reset");
        tick(1'b0, 1'b0, S, "short_after_reset");

        tick(1'b0, 1'b1, P, "short_press_edge");
        quiet(1'b1, 4, "short_hold");
        tick(1'b0, 1'b0, R, "short_release");
        quiet(1'b0, 9, "short_gap");
        tick(1'b0, 1'b0, S, "short_press_pulse");
        quiet(1'b0, 3, "short_idle");

        tick(1'b0, 1'b1, P, "dbl_first_press");
        quiet(1'b1, 4, "dbl_hold1");
        tick(1'b0, 1'b0, R, "dbl_first_release");
        quiet(1'b0, 3, "dbl_gap");
        tick(1'b0, 1'b1, P | D, "dbl_second_press");
        quiet(1'b1, 4, "dbl_hold2");
        tick(1'b0, 1'b0, R, "dbl_second_release");
        quiet(1'b0, 12, "dbl_no_short");

        tick(1'b0, 1'b1, P, "long_press_edge");
        quiet(1'b1, 19, "long_wait");
        tick(1'b0, 1'b1, L, "long_press_pulse");
        for (int k = 0; k < 3; k++) begin
            quiet(1'b1, 4, "repeat_wait");
            tick(1'b0, 1'b1, T, "repeat_tick_pulse");
        end
        tick(1'b0, 1'b1, Z, "long_last_hold");
        tick(1'b0, 1'b0, R, "long_release");
        quiet(1'b0, 12, "long_no_short");

        tick(1'b0, 1'b1, P, "bnd_long_press");
        quiet(1'b1, 19, "bnd_long_wait");
        tick(1'b0, 1'b0, R, "bnd_long_fall_wins");
        quiet(1'b0, 9, "bnd_long_gap");
        tick(1'b0, 1'b0, S, "bnd_long_short");

        tick(1'b0, 1'b1, P, "bnd_dbl_press");
        quiet(1'b1, 2, "bnd_dbl_hold");
        tick(1'b0, 1'b0, R, "bnd_dbl_release");
        quiet(1'b0, 9, "bnd_dbl_gap");
        tick(1'b0, 1'b1, P | D, "bnd_dbl_rise_wins");
        quiet(1'b1, 2, "bnd_dbl_hold2");
        tick(1'b0, 1'b0, R, "bnd_dbl_release2");
        quiet(1'b0, 12, "bnd_dbl_no_short");

        tick(1'b0, 1'b1, P, "late_press");
        quiet(1'b1, 2, "late_hold");
        tick(1'b0, 1'b0, R, "late_release");
        quiet(1'b0, 9, "late_gap");
        tick(1'b0, 1'b0, S, "late_short");
        tick(1'b0, 1'b1, P, "late_fresh_press_no_dbl");
        quiet(1'b1, 2, "late_hold2");
        tick(1'b0, 1'b0, R, "late_release2");
        quiet(1'b0, 9, "late_gap2");
        tick(1'b0, 1'b0, S, "late_short2");

        tick(1'b0, 1'b1, P, "mid_rst_press");
        quiet(1'b1, 3, "mid_rst_hold");
        tick(1'b1, 1'b1, Z, "mid_rst_a");
        tick(1'b1, 1'b1, Z, "mid_rst_b");
        tick(1'b0, 1'b0, Z, "mid_rst_no_release");
        quiet(1'b0, 25, "mid_rst_quiet");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
